basis_readout: RTL and testbench

- Reads back a computational basis state from its stabilizer rows; the inverse of the basis-literal generator.
- Accepts num_qubit stabilizer rows serially (literals + phase, one row per accepted beat).
- Checks that every row is a single ±Z_k, then assembles the basis bit vector.
- Sits at the tail of the stabilizer emulation pipeline, where it converts a final stabilizer tableau into a measurement outcome.

---
 rtl/stab_pkg.sv | 25 ++
 rtl/basis_readout_if.sv | 44 ++++
 rtl/row_classify.sv | 42 ++++
 rtl/basis_readout.sv | 147 ++++++++++++++
 tb/tb_basis_readout.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/stab_pkg.sv
// stab_pkg -- shared definitions for the stabilizer emulation pipeline.
//   pauli_t      : 2-bit Pauli literal (00 I, 01 Z, 10 X, 11 Y)
//   LIT_*        : literal encodings
//   PH_*         : row phase encodings (0 = +, 1 = -)
//   state_t      : basis_readout FSM states
//   idx_w()      : width of a qubit index, never less than 1
package stab_pkg;

    typedef logic [1:0] pauli_t;

    localparam pauli_t LIT_I = 2'b00;
    localparam pauli_t LIT_Z = 2'b01;
    localparam pauli_t LIT_X = 2'b10;
    localparam pauli_t LIT_Y = 2'b11;

    localparam logic PH_POS = 1'b0;
    localparam logic PH_NEG = 1'b1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/basis_readout_if.sv
// basis_readout_if -- row stream and result bus of basis_readout.
//   start, valid_in, literals_in, phase_in : producer -> readout
//   ready_out                              : readout -> producer
//   basis, done, basis_ok, err_not_basis,
//   err_dup                                : frame results
//   err_row_idx, err_row_vld               : only with BASIS_READOUT_ERR_IDX_EN
// Modports: master (row producer / result consumer), slave (basis_readout).
interface basis_readout_if
    import stab_pkg::*;
#(
    parameter int NUM_QUBIT = 3
);
    logic                            start;
    logic                            valid_in;
    logic                            ready_out;
    pauli_t [NUM_QUBIT-1:0]          literals_in;
    logic                            phase_in;
    logic   [NUM_QUBIT-1:0]          basis;
    logic                            done;
    logic                            basis_ok;
    logic                            err_not_basis;
    logic                            err_dup;
`ifdef BASIS_READOUT_ERR_IDX_EN
    logic   [idx_w(NUM_QUBIT)-1:0]   err_row_idx;
    logic                            err_row_vld;
`endif

    modport master (
        output start, valid_in, literals_in, phase_in,
        input  ready_out, basis, done, basis_ok, err_not_basis, err_dup
`ifdef BASIS_READOUT_ERR_IDX_EN
        , input err_row_idx, err_row_vld
`endif
    );

    modport slave (
        input  start, valid_in, literals_in, phase_in,
        output ready_out, basis, done, basis_ok, err_not_basis, err_dup
`ifdef BASIS_READOUT_ERR_IDX_EN
        , output err_row_idx, err_row_vld
`endif
    );

endinterface

// File: rtl/row_classify.sv
// row_classify -- combinational check of one stabilizer row.
//   literals_i : one Pauli literal per qubit
//   has_xy_o   : some literal is X or Y
//   z_one_o    : exactly one literal is Z
//   z_onehot_o : one-hot position(s) of Z literals
//   z_idx_o    : encoded Z position (meaningful only when z_one_o)
module row_classify
    import stab_pkg::*;
#(
    parameter int NUM_QUBIT = 3
) (
    input  pauli_t [NUM_QUBIT-1:0]        literals_i,
    output logic                          has_xy_o,
    output logic                          z_one_o,
    output logic [NUM_QUBIT-1:0]          z_onehot_o,
    output logic [idx_w(NUM_QUBIT)-1:0]   z_idx_o
);
    localparam int IW = idx_w(NUM_QUBIT);

    always_comb begin
        has_xy_o   = 1'b0;
        z_onehot_o = '0;
        z_idx_o    = '0;
        for (int k = 0; k < NUM_QUBIT; k++) begin
            case (literals_i[k])
                LIT_I:        ;
                LIT_Z: begin
                    z_onehot_o[k] = 1'b1;
                    // OR-encode; only trusted when a single Z is present
                    z_idx_o       = z_idx_o | IW'(k);
                end
                LIT_X, LIT_Y: has_xy_o = 1'b1;
                default:      ;
            endcase
        end
    end

    // power-of-two test: nonzero and no second bit set
    assign z_one_o = (z_onehot_o != '0) &&
                     ((z_onehot_o & (z_onehot_o - NUM_QUBIT'(1))) == '0);

endmodule

// File: rtl/basis_readout.sv
// basis_readout -- recovers a computational basis state from NUM_QUBIT
// stabilizer rows received one per accepted beat.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : basis_readout_if.slave (row stream in, basis/flags out)
// Optional macro BASIS_READOUT_ERR_IDX_EN adds err_row_idx/err_row_vld,
// the beat index of the first row that raised an error.
module basis_readout
    import stab_pkg::*;
#(
    parameter int NUM_QUBIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    basis_readout_if.slave bus
);
    localparam int CW = $clog2(NUM_QUBIT + 1);
    localparam int IW = idx_w(NUM_QUBIT);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_QUBIT-1:0]   basis_q, basis_d;
    logic [NUM_QUBIT-1:0]   mask_q, mask_d;
    logic                   nb_q, nb_d;
    logic                   dup_q, dup_d;
    logic                   ok_q, ok_d;

    logic                   has_xy, z_one;
    logic [NUM_QUBIT-1:0]   z_onehot;
    logic [IW-1:0]          z_idx;
    logic                   beat;

    row_classify #(.NUM_QUBIT(NUM_QUBIT)) u_cls (
        .literals_i (bus.literals_in),
        .has_xy_o   (has_xy),
        .z_one_o    (z_one),
        .z_onehot_o (z_onehot),
        .z_idx_o    (z_idx)
    );

    assign beat = (state_q == COLLECT) && bus.valid_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        basis_d = basis_q;
        mask_d  = mask_q;
        nb_d    = nb_q;
        dup_d   = dup_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    basis_d = '0;
                    mask_d  = '0;
                    nb_d    = 1'b0;
                    dup_d   = 1'b0;
                    ok_d    = 1'b0;
                end
            end
            COLLECT: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                    // bad rows leave basis untouched, so their phase is dropped
                    if (has_xy || !z_one)
                        nb_d = 1'b1;
                    else if ((mask_q & z_onehot) != '0)
                        dup_d = 1'b1;
                    else begin
                        mask_d         = mask_q | z_onehot;
                        basis_d[z_idx] = (bus.phase_in == PH_NEG);
                    end
                    if (cnt_q == CW'(NUM_QUBIT - 1)) begin
                        state_d = DONE;
                        // includes the final beat's flag/mask update
                        ok_d    = !nb_d && !dup_d && (&mask_d);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            basis_q <= '0;
            mask_q  <= '0;
            nb_q    <= 1'b0;
            dup_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            basis_q <= basis_d;
            mask_q  <= mask_d;
            nb_q    <= nb_d;
            dup_q   <= dup_d;
            ok_q    <= ok_d;
        end
    end

    assign bus.ready_out     = (state_q == COLLECT);
    assign bus.done          = (state_q == DONE);
    assign bus.basis         = basis_q;
    assign bus.basis_ok      = ok_q;
    assign bus.err_not_basis = nb_q;
    assign bus.err_dup       = dup_q;

`ifdef BASIS_READOUT_ERR_IDX_EN
    logic          row_bad;
    logic [IW-1:0] eidx_q, eidx_d;
    logic          evld_q, evld_d;

    assign row_bad = beat && (has_xy || !z_one || ((mask_q & z_onehot) != '0));

    always_comb begin
        eidx_d = eidx_q;
        evld_d = evld_q;
        if (state_q == IDLE && bus.start) begin
            eidx_d = '0;
            evld_d = 1'b0;
        end else if (row_bad && !evld_q) begin
            eidx_d = cnt_q[IW-1:0];
            evld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eidx_q <= '0;
            evld_q <= 1'b0;
        end else begin
            eidx_q <= eidx_d;
            evld_q <= evld_d;
        end
    end

    assign bus.err_row_idx = eidx_q;
    assign bus.err_row_vld = evld_q;
`endif

endmodule

// File: tb/tb_basis_readout.sv
// tb_basis_readout -- directed self-checking bench for basis_readout (3 qubits).
module tb_basis_readout;
    import stab_pkg::*;

    localparam int NQ = 3;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;

    basis_readout_if #(.NUM_QUBIT(NQ)) bus ();

    basis_readout #(.NUM_QUBIT(NQ)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---- stimulus helpers (drive only; inputs change on falling edges) ----
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic row_raw(input pauli_t [NQ-1:0] l, input logic ph);
        bus.literals_in = l;
        bus.phase_in    = ph;
        bus.valid_in    = 1'b1;
        @(negedge clk);
        bus.valid_in    = 1'b0;
    endtask

    task automatic row_z(input int k, input logic ph);
        pauli_t [NQ-1:0] l;
        l    = '0;
        l[k] = LIT_Z;
        row_raw(l, ph);
    endtask

    task automatic gap();
        bus.literals_in = {LIT_X, LIT_X, LIT_X};
        bus.phase_in    = PH_NEG;
        bus.valid_in    = 1'b0;
        @(negedge clk);
    endtask

    // ---- tests ----
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++; if (bus.ready_out !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", bus.ready_out); end
        n_chk++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        n_chk++; if (bus.basis !== 3'b000) begin n_bad++; $display("FAIL rst_basis got=%b want=000", bus.basis); end
        n_chk++; if ({bus.basis_ok, bus.err_not_basis, bus.err_dup} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b want=000", {bus.basis_ok, bus.err_not_basis, bus.err_dup}); end
`ifdef BASIS_READOUT_ERR_IDX_EN
        n_chk++; if ({bus.err_row_vld, bus.err_row_idx} !== 3'b000) begin n_bad++; $display("FAIL rst_eidx got=%b want=000", {bus.err_row_vld, bus.err_row_idx}); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // rows offered while idle are not consumed
        row_z(1, PH_NEG);
        n_chk++; if (bus.ready_out !== 1'b0 || bus.basis !== 3'b000) begin n_bad++; $display("FAIL idle_valid got=%b/%b want=0/000", bus.ready_out, bus.basis); end
    endtask

    task automatic test_clean();
        do_start();
        n_chk++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL clean_ready got=%b want=1", bus.ready_out); end
        row_z(0, PH_POS);
        row_z(1, PH_POS);
        n_chk++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL clean_early_done got=%b want=0", bus.done); end
        row_z(2, PH_POS);
        n_chk++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL clean_done got=%b want=1", bus.done); end
        n_chk++; if (bus.basis !== 3'b000) begin n_bad++; $display("FAIL clean_basis got=%b want=000", bus.basis); end
        n_chk++; if ({bus.basis_ok, bus.err_not_basis, bus.err_dup} !== 3'b100) begin n_bad++; $display("FAIL clean_flags got=%b want=100", {bus.basis_ok, bus.err_not_basis, bus.err_dup}); end
`ifdef BASIS_READOUT_ERR_IDX_EN
        n_chk++; if (bus.err_row_vld !== 1'b0) begin n_bad++; $display("FAIL clean_evld got=%b want=0", bus.err_row_vld); end
`endif
        @(negedge clk);
        n_chk++; if ({bus.done, bus.ready_out, bus.basis_ok} !== 3'b001) begin n_bad++; $display("FAIL clean_hold got=%b want=001", {bus.done, bus.ready_out, bus.basis_ok}); end
    endtask

    task automatic test_gaps();
        do_start();
        row_z(2, PH_NEG);
        gap();
        n_chk++; if ({bus.ready_out, bus.done} !== 2'b10) begin n_bad++; $display("FAIL gap_state got=%b want=10", {bus.ready_out, bus.done}); end
        row_z(0, PH_POS);
        gap();
        gap();
        n_chk++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL gap_done got=%b want=0", bus.done); end
        row_z(1, PH_NEG);
        n_chk++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL gap_done_end got=%b want=1", bus.done); end
        n_chk++; if (bus.basis !== 3'b110) begin n_bad++; $display("FAIL gap_basis got=%b want=110", bus.basis); end
        n_chk++; if (bus.basis_ok !== 1'b1) begin n_bad++; $display("FAIL gap_ok got=%b want=1", bus.basis_ok); end
        @(negedge clk);
    endtask

    task automatic test_xy();
        do_start();
        row_z(0, PH_POS);
        row_raw({LIT_I, LIT_I, LIT_X}, PH_NEG);
        row_z(2, PH_POS);
        n_chk++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL xy_done got=%b want=1", bus.done); end
        n_chk++; if ({bus.basis_ok, bus.err_not_basis, bus.err_dup} !== 3'b010) begin n_bad++; $display("FAIL xy_flags got=%b want=010", {bus.basis_ok, bus.err_not_basis, bus.err_dup}); end
        n_chk++; if (bus.basis !== 3'b000) begin n_bad++; $display("FAIL xy_basis got=%b want=000", bus.basis); end
`ifdef BASIS_READOUT_ERR_IDX_EN
        n_chk++; if ({bus.err_row_vld, bus.err_row_idx} !== 3'b101) begin n_bad++; $display("FAIL xy_eidx got=%b want=101", {bus.err_row_vld, bus.err_row_idx}); end
`endif
        @(negedge clk);
    endtask

    task automatic test_dup();
        do_start();
        row_z(1, PH_POS);
        row_z(1, PH_NEG);
        row_z(0, PH_POS);
        n_chk++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL dup_done got=%b want=1", bus.done); end
        n_chk++; if ({bus.basis_ok, bus.err_not_basis, bus.err_dup} !== 3'b001) begin n_bad++; $display("FAIL dup_flags got=%b want=001", {bus.basis_ok, bus.err_not_basis, bus.err_dup}); end
        n_chk++; if (bus.basis !== 3'b000) begin n_bad++; $display("FAIL dup_basis got=%b want=000", bus.basis); end
`ifdef BASIS_READOUT_ERR_IDX_EN
        n_chk++; if ({bus.err_row_vld, bus.err_row_idx} !== 3'b101) begin n_bad++; $display("FAIL dup_eidx got=%b want=101", {bus.err_row_vld, bus.err_row_idx}); end
`endif
        @(negedge clk);
    endtask

    task automatic test_all_i();
        do_start();
        n_chk++; if ({bus.err_dup, bus.basis_ok} !== 2'b00) begin n_bad++; $display("FAIL alli_clear got=%b want=00", {bus.err_dup, bus.basis_ok}); end
        row_z(0, PH_POS);
        row_raw({LIT_I, LIT_I, LIT_I}, PH_NEG);
        row_z(2, PH_NEG);
        n_chk++; if ({bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup} !== 4'b1010) begin n_bad++; $display("FAIL alli_flags got=%b want=1010", {bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup}); end
        n_chk++; if (bus.basis !== 3'b100) begin n_bad++; $display("FAIL alli_basis got=%b want=100", bus.basis); end
`ifdef BASIS_READOUT_ERR_IDX_EN
        n_chk++; if ({bus.err_row_vld, bus.err_row_idx} !== 3'b101) begin n_bad++; $display("FAIL alli_eidx got=%b want=101", {bus.err_row_vld, bus.err_row_idx}); end
`endif
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        do_start();
        row_z(0, PH_POS);
        bus.start = 1'b1;
        row_z(1, PH_NEG);
        bus.start = 1'b0;
        n_chk++; if ({bus.done, bus.basis} !== 4'b0010) begin n_bad++; $display("FAIL sti_mid got=%b want=0010", {bus.done, bus.basis}); end
        row_z(2, PH_POS);
        n_chk++; if ({bus.done, bus.basis_ok, bus.basis} !== 5'b11010) begin n_bad++; $display("FAIL sti_done got=%b want=11010", {bus.done, bus.basis_ok, bus.basis}); end
        // start during DONE is dropped: next cycle is IDLE, results kept
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_chk++; if ({bus.ready_out, bus.basis_ok, bus.basis} !== 5'b01010) begin n_bad++; $display("FAIL sti_in_done got=%b want=01010", {bus.ready_out, bus.basis_ok, bus.basis}); end
    endtask

    task automatic test_abort();
        do_start();
        row_z(0, PH_NEG);
        row_z(0, PH_NEG);
        n_chk++; if ({bus.err_dup, bus.basis} !== 4'b1001) begin n_bad++; $display("FAIL abort_pre got=%b want=1001", {bus.err_dup, bus.basis}); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.ready_out, bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup, bus.basis} !== 8'b0) begin n_bad++; $display("FAIL abort_rst got=%b want=00000000", {bus.ready_out, bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup, bus.basis}); end
        @(negedge clk);
        rst_n = 1'b1;
        row_z(2, PH_POS);
        row_z(1, PH_POS);
        n_chk++; if ({bus.ready_out, bus.done} !== 2'b00) begin n_bad++; $display("FAIL abort_nodone got=%b want=00", {bus.ready_out, bus.done}); end
        do_start();
        row_z(2, PH_POS);
        row_z(0, PH_NEG);
        row_z(1, PH_POS);
        n_chk++; if ({bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup, bus.basis} !== 7'b1100001) begin n_bad++; $display("FAIL abort_fresh got=%b want=1100001", {bus.done, bus.basis_ok, bus.err_not_basis, bus.err_dup, bus.basis}); end
        @(negedge clk);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.valid_in    = 1'b0;
        bus.literals_in = '0;
        bus.phase_in    = PH_POS;
        test_reset();
        test_clean();
        test_gaps();
        test_xy();
        test_dup();
        test_all_i();
        test_start_ignored();
        test_abort();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
